serial_adder_ctrl: RTL and testbench



---
 rtl/full_adder.sv | 15 +
 rtl/serial_adder_ctrl.sv | 157 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell (s = x^y^z, c = majority).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first, through one full_adder cell.
// Latency: busy for WIDTH cycles after the start edge; done pulses in the following cycle.
// Backpressure: none; start is honoured only in IDLE and ignored in RUN/DONE.
// Optional: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;
    logic             load;
    logic             step;
    logic             last;

    // The single one-bit datapath: current operand LSBs plus the running carry.
    full_adder u_fa (op_a[0], op_b[0], carry_q, fa_s, fa_c);

    // Sum assembled so far with this cycle's bit entering at the MSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_nxt = fa_s;
        end else begin : g_sum_wn
            assign sum_nxt = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    assign load = (state_q == IDLE) && start;
    assign step = (state_q == RUN);
    assign last = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE lasts exactly one cycle.
    always_comb begin
        state_nxt = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/sum shift registers, carry flop and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            op_a    <= a;
            op_b    <= b;
            sum_sh  <= '0;
            carry_q <= cin;
            cnt     <= '0;
        end else if (step) begin
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            sum_sh  <= sum_nxt;
            carry_q <= fa_c;
            cnt     <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Result registers: only touched on the final bit, so they hold across loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (step && last) begin
            sum_q  <= sum_nxt;
            cout_q <= fa_c;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the final bit carry_q is the carry into the MSB and fa_c the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (step && last) begin
            ovf_q <= carry_q ^ fa_c;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: checks an 8-bit and a 1-bit serial adder against arithmetic.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    int         n_chk  = 0;
    int         n_fail = 0;

    logic [7:0] last_sum;
    logic       last_cout;
    logic       last_ovf;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout8),
        .ovf   (ovf8)
`else
        .cout  (cout8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout1),
        .ovf   (ovf1)
`else
        .cout  (cout1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Signed two's-complement overflow of a + b + cin at width w.
    function automatic bit ovf_model(input int unsigned av, input int unsigned bv,
                                     input int unsigned ci, input int w);
        int sa;
        int sb;
        int s;
        sa = (av >= (32'd1 << (w - 1))) ? int'(av) - (1 << w) : int'(av);
        sb = (bv >= (32'd1 << (w - 1))) ? int'(bv) - (1 << w) : int'(bv);
        s  = sa + sb + int'(ci);
        return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    endfunction

    // One 8-bit operation; hold keeps start high and scrambles operands during RUN.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input bit hold);
        int          busy_n;
        int          done_n;
        int          done_at;
        int unsigned exp;
        bit          ov;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        exp     = int'(av) + int'(bv) + int'(ci);
        ov      = ovf_model(av, bv, ci, 8);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start8 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("sum_held_on_load", sum8, last_sum);
                chk("cout_held_on_load", cout8, last_cout);
            end
            if (hold && i == 2) begin
                a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            end
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (done_at == 0) done_at = i;
                start8 = 1'b0;
                chk("busy_low_in_done", busy8, 0);
            end
        end
        chk("busy_cycles", busy_n, 8);
        chk("done_pulses", done_n, 1);
        chk("done_timing", done_at, 9);
        chk("sum", sum8, exp & 32'hFF);
        chk("cout", cout8, (exp >> 8) & 32'h1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf8, ov);
`endif
        last_sum  = exp[7:0];
        last_cout = exp[8];
        last_ovf  = ov;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;

        // Reset values, then idle with start low.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_busy", busy8, 0);
            chk("idle_done", done8, 0);
        end

        // Directed cases.
        op8(8'h35, 8'h4A, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'h7F, 8'h00, 1'b1, 1'b0);
        op8(8'h10, 8'h20, 1'b0, 1'b1);

        // Reset after the third RUN edge: everything clears, no done appears.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", busy8, 0);
        chk("midrun_rst_sum", sum8, 0);
        chk("midrun_rst_cout", cout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dn;
            dn = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done8 || busy8) dn++;
            end
            chk("no_done_after_rst", dn, 0);
        end
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        op8(8'h01, 8'h01, 1'b0, 1'b0);

        // Random operations.
        for (int n = 0; n < 30; n++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
        end

        // WIDTH=1: full truth table.
        for (int i = 0; i < 8; i++) begin
            logic ai;
            logic bi;
            logic ci;
            int   e;
            ai = i[2]; bi = i[1]; ci = i[0];
            e  = int'(ai) + int'(bi) + int'(ci);
            @(negedge clk);
            a1 = ai; b1 = bi; cin1 = ci; start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0;
            @(negedge clk);
            chk("w1_busy", busy1, 1);
            chk("w1_done_early", done1, 0);
            @(negedge clk);
            chk("w1_done", done1, 1);
            chk("w1_busy_in_done", busy1, 0);
            chk("w1_sum", sum1, e & 1);
            chk("w1_cout", cout1, (e >> 1) & 1);
`ifdef SERIAL_ADDER_OVF_EN
            chk("w1_ovf", ovf1, ovf_model(ai, bi, ci, 1));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
